// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dm_access_ctrl
//  Purpose  : Memory-stage controller. Decodes the opcode held in the EX/MEM
//             register, runs a req/ack handshake with a variable-latency data
//             memory, freezes the upstream pipeline while the access is in
//             flight, injects MEM/WB bubbles, and aborts accesses that exceed
//             TIMEOUT cycles (setting a sticky error flag).
//  Ports    :
//    clk        in   1   clock, rising edge
//    rstd       in   1   asynchronous, active-low reset
//    op_in      in   6   opcode from EX/MEM (NOP = 6'b110111)
//    addr_in    in  32   data-memory address from EX/MEM
//    wdata_in   in  32   store data from EX/MEM
//    dm_req     out  1   registered memory request
//    dm_we      out  1   1 = store, 0 = load (valid while dm_req = 1)
//    dm_addr    out 32   latched access address
//    dm_wdata   out 32   latched store data
//    dm_ack     in   1   memory completion (only honoured in ACCESS)
//    dm_rdata   in  32   load data, valid with dm_ack
//    stall      out  1   hold PC .. EX/MEM (combinational)
//    wb_bubble  out  1   MEM/WB loads NOP this edge (same as stall)
//    load_data  out 32   registered load result
//    err        out  1   sticky timeout flag
//  Revision : 1.0 - initial release
// ============================================================================
module dm_access_ctrl #(
    parameter int          TIMEOUT = 16,          // legal range 1..255
    parameter logic [5:0]  OP_LW   = 6'b100011,
    parameter logic [5:0]  OP_SW   = 6'b101011
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic [5:0]  op_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        wb_bubble,
    output logic [31:0] load_data,
    output logic        err
);

    // Last counter value at which an un-acked request is still allowed to
    // wait; with the counter starting at 0 this keeps dm_req high for exactly
    // TIMEOUT cycles.
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        dm_req_q;
    logic        dm_we_q;
    logic [31:0] dm_addr_q;
    logic [31:0] dm_wdata_q;
    logic [31:0] load_data_q;
    logic        err_q;

    logic        w_is_mem;

    assign w_is_mem = (op_in == OP_LW) || (op_in == OP_SW);

    // The freeze must be visible in the same cycle the memory op is detected,
    // so stall is decoded from the current state rather than registered.
    // DONE is deliberately excluded: the pipeline advances as it ends.
    assign stall     = ((state_q == S_IDLE) && w_is_mem) || (state_q == S_ACCESS);
    assign wb_bubble = stall;

    assign dm_req    = dm_req_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = dm_wdata_q;
    assign load_data = load_data_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= 32'd0;
            dm_wdata_q  <= 32'd0;
            load_data_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_is_mem) begin
                        state_q    <= S_ACCESS;
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= (op_in == OP_SW);
                        dm_addr_q  <= addr_in;
                        dm_wdata_q <= wdata_in;
                        cnt_q      <= 8'd0;
                    end
                end

                S_ACCESS: begin
                    // Ack is checked first so a completion arriving on the
                    // final permitted cycle is never reported as a timeout.
                    if (dm_ack) begin
                        state_q  <= S_DONE;
                        dm_req_q <= 1'b0;
                        if (!dm_we_q) begin
                            load_data_q <= dm_rdata;
                        end
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q  <= S_DONE;
                        dm_req_q <= 1'b0;
                        err_q    <= 1'b1;
                        if (!dm_we_q) begin
                            load_data_q <= 32'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                // The op is still present in EX/MEM here; it must not be
                // decoded again, so DONE always returns to IDLE.
                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_access_ctrl
//  Purpose  : Self-checking bench for dm_access_ctrl. Each opcode is treated
//             as one transaction whose expected stall length, request window,
//             load result and error flag are derived from the transaction's
//             memory latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_access_ctrl;

    localparam int         c_TO     = 4;
    localparam logic [5:0] c_OP_LW  = 6'b100011;
    localparam logic [5:0] c_OP_SW  = 6'b101011;
    localparam logic [5:0] c_OP_NOP = 6'b110111;
    localparam logic [5:0] c_OP_ALU = 6'b000000;

    logic        clk;
    logic        rstd;
    logic [5:0]  op_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall;
    logic        wb_bubble;
    logic [31:0] load_data;
    logic        err;

    int          n_checks;
    int          n_errors;

    // Transaction-level model state
    logic [31:0] m_load;
    logic        m_err;

    dm_access_ctrl #(
        .TIMEOUT (c_TO),
        .OP_LW   (c_OP_LW),
        .OP_SW   (c_OP_SW)
    ) u_dut (
        .clk       (clk),
        .rstd      (rstd),
        .op_in     (op_in),
        .addr_in   (addr_in),
        .wdata_in  (wdata_in),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .stall     (stall),
        .wb_bubble (wb_bubble),
        .load_data (load_data),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One EX/MEM occupancy. lat = number of wait cycles before ack; lat >= c_TO
    // means memory never answers. Called just after a rising edge with the
    // controller idle; returns just after the edge that ends the op.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int lat, input bit noise);
        bit is_mem;
        bit is_load;
        bit timed_out;
        int n_stall;
        int n_req;
        bit exp_req;

        is_mem    = (op == c_OP_LW) || (op == c_OP_SW);
        is_load   = (op == c_OP_LW);
        timed_out = is_mem && (lat >= c_TO);
        n_stall   = !is_mem ? 0 : (timed_out ? c_TO + 1 : lat + 2);
        n_req     = !is_mem ? 0 : (timed_out ? c_TO : lat + 1);

        if (is_mem) begin
            if (is_load) m_load = timed_out ? 32'd0 : rdata;
            m_err = m_err | timed_out;
        end

        op_in    = op;
        addr_in  = addr;
        wdata_in = wdata;

        for (int i = 0; i <= n_stall; i++) begin
            if (is_mem && !timed_out && i == lat + 1) begin
                dm_ack   = 1'b1;
                dm_rdata = rdata;
            end else begin
                dm_ack   = (noise && (i == 0 || i == n_stall)) ? 1'($urandom_range(0, 1)) : 1'b0;
                dm_rdata = $urandom;
            end
            exp_req = is_mem && (i >= 1) && (i <= n_req);

            @(negedge clk);
            chk("stall", {31'd0, stall}, {31'd0, (i < n_stall)});
            chk("wb_bubble", {31'd0, wb_bubble}, {31'd0, (i < n_stall)});
            chk("dm_req", {31'd0, dm_req}, {31'd0, exp_req});
            if (exp_req) begin
                chk("dm_addr", dm_addr, addr);
                chk("dm_we", {31'd0, dm_we}, {31'd0, !is_load});
                if (!is_load) chk("dm_wdata", dm_wdata, wdata);
            end
            if (i == n_stall) begin
                chk("load_data", load_data, m_load);
                chk("err", {31'd0, err}, {31'd0, m_err});
            end
            @(posedge clk);
            #1;
        end
        dm_ack = 1'b0;
    endtask

    // Reset asserted while a load is waiting for memory.
    task automatic reset_mid_access();
        op_in    = c_OP_LW;
        addr_in  = 32'h0000_0ABC;
        wdata_in = 32'h0;
        dm_ack   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_req", {31'd0, dm_req}, 32'd1);
        rstd = 1'b0;
        #1;
        chk("rst_req_async", {31'd0, dm_req}, 32'd0);
        op_in = c_OP_NOP;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_load", load_data, 32'd0);
        m_load = 32'd0;
        m_err  = 1'b0;
        @(posedge clk); #1;
        rstd = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rop;
        int         sel;
        int         lat;

        n_checks = 0;
        n_errors = 0;
        m_load   = 32'd0;
        m_err    = 1'b0;
        rstd     = 1'b0;
        op_in    = c_OP_NOP;
        addr_in  = 32'h0;
        wdata_in = 32'h0;
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", {31'd0, dm_req}, 32'd0);
        chk("reset_we", {31'd0, dm_we}, 32'd0);
        chk("reset_addr", dm_addr, 32'd0);
        chk("reset_wdata", dm_wdata, 32'd0);
        chk("reset_load", load_data, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        op_in = c_OP_ALU;
        #1;
        chk("reset_alu_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rstd = 1'b1;

        // Directed cases
        run_op(c_OP_NOP, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        run_op(c_OP_ALU, 32'h44, 32'h55, 32'h0, 0, 1'b0);
        run_op(c_OP_LW, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
        run_op(c_OP_SW, 32'h200, 32'h1234_5678, 32'hDEAD_BEEF, 3, 1'b0);
        run_op(c_OP_LW, 32'h300, 32'h0, 32'h1111_2222, 1, 1'b0);
        run_op(c_OP_SW, 32'h304, 32'hA5A5_5A5A, 32'h0, 0, 1'b0);
        run_op(c_OP_LW, 32'h400, 32'h0, 32'h7777_7777, c_TO, 1'b0);
        run_op(c_OP_NOP, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        reset_mid_access();
        run_op(c_OP_LW, 32'h500, 32'h0, 32'h0BAD_CAFE, c_TO - 1, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: rop = c_OP_LW;
                1: rop = c_OP_SW;
                2: rop = c_OP_NOP;
                default: begin
                    rop = 6'($urandom_range(0, 63));
                    while (rop == c_OP_LW || rop == c_OP_SW) rop = 6'($urandom_range(0, 63));
                end
            endcase
            lat = ($urandom_range(0, 7) == 0) ? c_TO : $urandom_range(0, c_TO - 1);
            run_op(rop, $urandom, $urandom, $urandom, lat, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Memory-stage controller that sequences data-memory accesses for the instruction held in the EX/MEM pipeline register. It decodes the held opcode, runs a req/ack handshake with a variable-latency data memory, freezes the upstream pipeline (PC through EX/MEM) while the access is outstanding, and injects bubbles into MEM/WB. It also aborts accesses that exceed a timeout and flags a sticky error.

## Interface
- TIMEOUT, 16, max cycles dm_req is held without dm_ack before abort; legal range 1..255
- OP_LW, 6'b100011, load opcode
- OP_SW, 6'b101011, store opcode
- clk  in  1  clock, rising edge
- rstd  in  1  reset, asynchronous, active-low
- op_in  in  6  opcode from EX/MEM register; NOP is 6'b110111
- addr_in  in  32  data-memory address from EX/MEM register
- wdata_in  in  32  store data from EX/MEM register
- dm_req  out  1  memory request, registered
- dm_we  out  1  1 = store, 0 = load; valid while dm_req=1
- dm_addr  out  32  latched access address
- dm_wdata  out  32  latched store data
- dm_ack  in  1  memory completion; sampled only in ACCESS
- dm_rdata  in  32  load data; valid when dm_ack=1
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM (combinational)
- wb_bubble  out  1  MEM/WB loads NOP this edge; equals stall
- load_data  out  32  registered load result
- err  out  1  sticky timeout flag

## Operation
- is_mem = (op_in == OP_LW) || (op_in == OP_SW); all other opcodes, including NOP, pass through with no stall.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, is_mem=0: stay; stall=0.
- IDLE, is_mem=1: stall=1. Next edge: go to ACCESS; dm_req<=1; dm_we<=(op_in==OP_SW); latch dm_addr<=addr_in and dm_wdata<=wdata_in; clear the counter.
- ACCESS: stall=1; dm_req held at 1 and all dm_* outputs held stable.
  - dm_ack=1: go to DONE; dm_req<=0; if the access is a load, load_data<=dm_rdata.
  - dm_ack=0 and counter==TIMEOUT-1: go to DONE; dm_req<=0; err<=1; for a load, load_data<=32'h0.
  - Otherwise the counter increments by 1. The counter is 8 bits and never wraps, because the timeout fires first.
- DONE: stall=0, so the pipeline advances at the end of this cycle. load_data is valid to MEM/WB during this cycle. Unconditional transition to IDLE. The held op is not re-decoded in DONE.
- dm_ack and timeout expiry in the same cycle: ack wins; err is not set.
- A store leaves load_data unchanged.
- err is cleared only by rstd.
- dm_ack outside ACCESS is ignored.

## Timing
- Reset values: state IDLE; dm_req, dm_we, err = 0; dm_addr, dm_wdata, load_data = 0; counter 0. stall=0 after reset because EX/MEM resets to NOP.
- Asserting rstd mid-access drops dm_req asynchronously; no completion is reported.
- Minimum memory-op occupancy is 3 cycles (IDLE-detect, ACCESS, DONE) with stall high for 2 of them. Each extra cycle of memory latency adds 1 stall cycle.
  - Op appears in EX/MEM at cycle T: stall=1 at T.
  - dm_req=1 from T+1.
  - Ack at T+1+k gives DONE at T+2+k, with stall=0 and load_data valid.
- Timeout: with no ack, dm_req is high for exactly TIMEOUT cycles, then DONE follows.
- Back-to-back memory ops: the second op enters EX/MEM at the DONE edge and is detected in IDLE the next cycle. There is no dead cycle beyond IDLE-detect.
- Non-memory ops: zero added latency.

## Test plan
- Reset with op_in=NOP and an ALU op (6'b000000) -> all outputs 0, stall stays 0 throughout.
- LW addr 0x100, dm_ack in the first ACCESS cycle with dm_rdata=0xCAFEF00D -> stall high for 2 cycles, dm_req high 1 cycle with dm_we=0 and dm_addr=0x100, load_data=0xCAFEF00D in DONE.
- SW addr 0x200 data 0x12345678, ack after 3 wait cycles -> dm_we=1, dm_wdata=0x12345678, stall high for 5 cycles, load_data unchanged.
- LW then SW back-to-back -> two separate request windows, dm_addr/we correct for each, no duplicate request for either op.
- TIMEOUT=4, no ack -> dm_req high exactly 4 cycles, err=1 sticky, load_data=0, stall released. Repeat with ack on the 4th cycle -> err stays 0.
- rstd pulsed low during ACCESS -> dm_req falls immediately, state IDLE, err=0, no stall once EX/MEM returns NOP.
